// File: rtl/spi_peripheral.sv
// SPI mode-0 register-write target feeding the PWM block's five control registers.
// Optional CIPO readback path is compiled in with `define SPI_READBACK_EN.
//
// state | meaning
// IDLE  | nCS high, waiting for a fresh nCS fall
// RX    | nCS low, shifting COPI on each SCLK rise
// OVF   | more than 16 SCLK rises seen; frame is discarded
module spi_peripheral #(
    parameter int MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        OVF  = 2'd2
    } state_t;

    localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);

    logic [2:0]  sclk_sh;
    logic [2:0]  ncs_sh;
    logic [1:0]  copi_sh;
    logic        sclk_rise;
    logic        ncs_fall;
    logic        ncs_rise;
    logic        copi_s;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  bit_cnt;
    logic [15:0] shift_q;
    logic        commit;

    // nCS chain resets low so a frame already in progress at reset release
    // never produces a fall and is ignored until nCS goes high and low again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sh <= 3'b000;
            ncs_sh  <= 3'b000;
            copi_sh <= 2'b00;
        end else begin
            sclk_sh <= {sclk_sh[1:0], sclk};
            ncs_sh  <= {ncs_sh[1:0], ncs};
            copi_sh <= {copi_sh[0], copi};
        end
    end

    assign sclk_rise = sclk_sh[1] & ~sclk_sh[2];
    assign ncs_fall  = ~ncs_sh[1] & ncs_sh[2];
    assign ncs_rise  = ncs_sh[1] & ~ncs_sh[2];
    assign copi_s    = copi_sh[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ncs_fall) state_d = RX;
            end
            RX: begin
                if (ncs_rise)                             state_d = IDLE;
                else if (sclk_rise && bit_cnt == 5'd16)   state_d = OVF;
            end
            OVF: begin
                if (ncs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            shift_q <= 16'h0000;
        end else if (state_q == IDLE && ncs_fall) begin
            bit_cnt <= 5'd0;
            shift_q <= 16'h0000;
        end else if (state_q == RX && sclk_rise && !ncs_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            shift_q <= {shift_q[14:0], copi_s};
        end
    end

    assign commit = (state_q == RX) && ncs_rise && (bit_cnt == 5'd16) &&
                    shift_q[15] && (shift_q[14:8] <= ADDR_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (commit) begin
            case (shift_q[14:8])
                7'd0:    en_reg_out_7_0  <= shift_q[7:0];
                7'd1:    en_reg_out_15_8 <= shift_q[7:0];
                7'd2:    en_reg_pwm_7_0  <= shift_q[7:0];
                7'd3:    en_reg_pwm_15_8 <= shift_q[7:0];
                7'd4:    pwm_duty_cycle  <= shift_q[7:0];
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] hdr;
    logic [7:0] rd_data;
    logic [7:0] tx_q;
    logic       rd_q;

    assign sclk_fall = ~sclk_sh[1] & sclk_sh[2];
    // Header byte as it will stand once the 8th rise has been shifted in.
    assign hdr = {shift_q[6:0], copi_s};

    always_comb begin
        rd_data = 8'h00;
        case (hdr[6:0])
            7'd0:    rd_data = en_reg_out_7_0;
            7'd1:    rd_data = en_reg_out_15_8;
            7'd2:    rd_data = en_reg_pwm_7_0;
            7'd3:    rd_data = en_reg_pwm_15_8;
            7'd4:    rd_data = pwm_duty_cycle;
            default: rd_data = 8'h00;
        endcase
    end

    // First shift is on the fall after rise 9 so rise 9 still sees data bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 8'h00;
            rd_q <= 1'b0;
            cipo <= 1'b0;
        end else begin
            if (state_q != RX || ncs_rise) begin
                rd_q <= 1'b0;
            end else if (sclk_rise && bit_cnt == 5'd7 && !hdr[7] &&
                         hdr[6:0] <= ADDR_LIMIT) begin
                tx_q <= rd_data;
                rd_q <= 1'b1;
            end else if (rd_q && sclk_fall && bit_cnt >= 5'd9) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
            cipo <= (state_d == RX && rd_q) ? tx_q[7] : 1'b0;
        end
    end
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: random and directed SPI frames checked
// against a frame-level model of the register file and CIPO readback.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    spi_peripheral #(.MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [39:0] regs;
        logic [15:0] cb;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  m_regs[5];
    logic [15:0] act_cipo;
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    function automatic logic [39:0] model_regs();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Frame-level reference: what the master should see on CIPO and what the
    // registers should hold once the frame has ended.
    task automatic model_frame(input logic [15:0] frame, input int n);
        exp_t        e;
        int          lim;
        int          addr;
        e.cb = 16'h0000;
        addr = int'(frame[14:8]);
        lim  = (n < 16) ? n : 16;
        if (READBACK && !frame[15] && addr <= 4) begin
            for (int r = 9; r <= lim; r++) e.cb[r-1] = m_regs[addr][16-r];
        end
        if (n == 16 && frame[15] && addr <= 4) m_regs[addr] = frame[7:0];
        e.regs = model_regs();
        sb_q.push_back(e);
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b, input int idx);
        copi = b;
        clk_n(8);
        if (idx < 16) act_cipo[idx] = cipo;
        sclk = 1'b1;
        clk_n(8);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] frame, input int n);
        logic b;
        model_frame(frame, n);
        act_cipo = 16'h0000;
        ncs = 1'b0;
        clk_n(8);
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
            shift_bit(b, i);
        end
        clk_n(8);
        ncs = 1'b1;
        clk_n(12);
    endtask

    task automatic send_reset_frame(input logic [15:0] frame);
        exp_t e;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        e.regs = 40'h0;
        e.cb   = 16'h0000;
        sb_q.push_back(e);
        act_cipo = 16'h0000;
        ncs = 1'b0;
        clk_n(8);
        for (int i = 0; i < 10; i++) shift_bit(frame[15-i], i);
        clk_n(2);
        rst_n = 1'b0;
        clk_n(3);
        check("mid_frame_reset_regs", dut_regs(), 40'h0);
        check("mid_frame_reset_cipo", {39'h0, cipo}, 40'h0);
        rst_n = 1'b1;
        clk_n(4);
        for (int i = 10; i < 16; i++) shift_bit(frame[15-i], i);
        clk_n(8);
        ncs = 1'b1;
        clk_n(12);
    endtask

    task automatic glitch_and_stray_sclk();
        exp_t e;
        e.regs = model_regs();
        e.cb   = 16'h0000;
        sb_q.push_back(e);
        act_cipo = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            copi = 1'b1;
            sclk = 1'b1;
            clk_n(8);
            sclk = 1'b0;
            clk_n(8);
        end
        ncs = 1'b0;
        clk_n(1);
        ncs = 1'b1;
        clk_n(12);
    endtask

    // Monitor: every nCS rise ends a frame; the registers must have settled
    // within four clocks, and the captured CIPO bits must match the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge ncs);
            if (sb_q.size() == 0) continue;
            repeat (4) @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check("frame_regs", dut_regs(), e.regs);
            check("frame_cipo", {24'h0, act_cipo}, {24'h0, e.cb});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] frame;
        int          n;
        int          sel;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        act_cipo = 16'h0000;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        clk_n(3);
        check("reset_regs", dut_regs(), 40'h0);
        check("reset_cipo", {39'h0, cipo}, 40'h0);
        rst_n = 1'b1;
        clk_n(10);

        send_frame(16'h80A5, 16);
        send_frame(16'h8480, 16);
        send_frame(16'h83F0, 16);
        send_frame(16'h85FF, 16);
        send_frame(16'h0011, 16);
        send_frame(16'h8177, 15);
        send_frame(16'h8177, 17);
        send_frame(16'h8177, 16);
        send_reset_frame(16'h8233);
        send_frame(16'h8480, 16);
        send_frame(16'h0400, 16);
        glitch_and_stray_sclk();
        send_frame(16'h8255, 16);

        for (int k = 0; k < 40; k++) begin
            frame[15]   = ($urandom_range(0, 3) != 0);
            frame[14:8] = 7'($urandom_range(0, 6));
            frame[7:0]  = 8'($urandom);
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            send_frame(frame, n);
        end

        clk_n(10);
        check("scoreboard_drained", 40'(sb_q.size()), 40'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
